led_pwm_cmd_ctrl: RTL and testbench
===================================

# led_pwm_cmd_ctrl

- Parametrised multi-channel LED controller driven by an ASCII byte command stream.
- Generalises the fixed three-channel RGB toggle machine to `CHANNELS` outputs, each with an on/off enable and a `PWM_BITS`-wide brightness level.
- Sits between the command byte source (UART receiver) and the board LED pins.
- Multi-byte commands are parsed by a small FSM with an inter-byte timeout; brightness is produced by a shared free-running PWM counter.

## Interface
Parameters:
- `CHANNELS`, 3 — number of LED channels, 1..16.
- `PWM_BITS`, 8 — brightness resolution, 2..12.
- `TIMEOUT`, 1000000 — max cycles between bytes of one multi-byte command, ≥2.
- `ACTIVE_LOW`, 1 — 1: pin low = lit; 0: pin high = lit.

Ports:
- `Clock` in 1 — single clock; everything is synchronous to its rising edge.
- `Reset` in 1 — asynchronous, active-low reset; asserting it resets all state immediately.
- `Cmd` in 8 — command/data byte.
- `CmdValid` in 1 — `Cmd` is sampled on every rising edge where `CmdValid` is 1; one byte per cycle max.
- `Led` out `CHANNELS` — registered LED pin drive, polarity per `ACTIVE_LOW`.
- `Enabled` out `CHANNELS` — registered per-channel enable state, active-high.
- `CmdError` out 1 — one-cycle pulse on a rejected command.

## Operation
- Per-channel state:
  - `en[i]`, reset 0.
  - `lvl_shadow[i]` and `lvl_active[i]`, both reset to all-ones (2^PWM_BITS−1).
- Commands recognised in `IDLE`; any other byte in `IDLE` is an error:
  - 82 `R` / 71 `G` / 66 `B`: toggle `en` of channel 0 / 1 / 2. If that channel index ≥ `CHANNELS`, error, no change.
  - 84 `T`: go to `T_IDX`. The next byte is a raw binary index; if it is < `CHANNELS`, toggle that channel.
  - 76 `L`: go to `L_IDX`, then `L_LVL`. The index byte is raw binary; the level byte's low `PWM_BITS` bits are written to `lvl_shadow[idx]`, and its upper bits are ignored.
  - 88 `X`: clear all `en`. Levels are unchanged.
- FSM transitions:
  - `IDLE` → `T_IDX` / `L_IDX` on `T` / `L`.
  - `T_IDX` → `IDLE` on any valid byte.
  - `L_IDX` → `L_LVL` on an in-range index, or → `IDLE` with error on an out-of-range index.
  - `L_LVL` → `IDLE` on any valid byte.
- In `T_IDX`, `L_IDX` and `L_LVL`, every byte is data. `R`/`G`/`B`/`X` values are not interpreted there.
- Out-of-range index in `T_IDX`: error, no change.
- Timeout:
  - Counter cleared on entry to a non-IDLE state and on each accepted byte.
  - When it reaches `TIMEOUT` cycles with no valid byte, FSM → `IDLE`, `CmdError` pulses, and the partial command is discarded. No register changes.
- PWM:
  - Counter `pc` counts 0..2^PWM_BITS−2, then wraps to 0. Period = 2^PWM_BITS−1 cycles.
  - Channel lit iff `en[i]` and `pc < lvl_active[i]`.
  - Level 0 is always dark; the all-ones level is always lit.
- Glitch-free update: all `lvl_active` load from `lvl_shadow` on the edge where `pc` wraps from 2^PWM_BITS−2 to 0.
- `Led[i]` = lit XOR `ACTIVE_LOW`, registered.

## Timing
- Reset values:
  - `Led` = all ones if `ACTIVE_LOW`, else all zeros (all dark).
  - `Enabled` = 0, `CmdError` = 0, FSM = `IDLE`, `pc` = 0, timeout counter = 0.
- Toggle / `X`:
  - `en` and `Enabled` update on the edge that samples the final command byte.
  - `Led` reflects the change one edge later.
- Level write:
  - `lvl_shadow` updates on the edge that samples the level byte.
  - It takes effect at the next `pc` wrap; a write landing on the wrap edge itself takes effect at the following wrap.
- `CmdError`: high for exactly the one cycle after the offending byte edge or the timeout edge.
- Back-to-back bytes (`CmdValid` held high) are fully supported; there is no backpressure.
- Reset mid-command: FSM returns to `IDLE` asynchronously, the partial command is lost, and `lvl_shadow` resets as well.

## Test plan
Bench configuration: `CHANNELS`=3, `PWM_BITS`=4, `TIMEOUT`=16, `ACTIVE_LOW`=1 unless stated.
- Reset release, send `R`, `G`, `B` → `Enabled` goes 001, 011, 111. With all levels at 15 (period 15), `Led`=000 continuously from one cycle after the `B` edge.
- `L`,1,4 then `G` → the Led[1] low pulse is 4 of every 15 cycles, starting only at the first `pc` wrap after the level byte. Led[0] and Led[2] are unaffected.
- `T`,3 → `CmdError` is a single-cycle pulse, `Enabled` unchanged, FSM back in `IDLE`. A following `T`,0 toggles channel 0.
- `L`,0 then 20 idle cycles → `CmdError` pulses after 16 idle cycles. A subsequent `L`,0,0 sets channel 0 level 0, so `Led[0]`=1 permanently even with `en[0]`=1.
- Byte 0x41 in `IDLE` → `CmdError` pulse. Then `X` → `Enabled`=000 and `Led`=111 one cycle later.
- Assert `Reset` low in the middle of `L`,2 (before the level byte) → all outputs return to reset values immediately. After release, a lone level byte 7 is treated as an `IDLE` byte and flagged as an error.

Source files
------------

// File: rtl/led_pwm_cmd_ctrl.sv
// rtl/led_pwm_cmd_ctrl.sv - multi-channel LED PWM controller driven by an ASCII command byte stream
module led_pwm_cmd_ctrl #(
    parameter int CHANNELS   = 3,
    parameter int PWM_BITS   = 8,
    parameter int TIMEOUT    = 1000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [7:0]          Cmd,
    input  logic                CmdValid,
    output logic [CHANNELS-1:0] Led,
    output logic [CHANNELS-1:0] Enabled,
    output logic                CmdError
);

    localparam int                TW      = $clog2(TIMEOUT + 1);
    localparam logic [PWM_BITS-1:0] PC_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};
    localparam logic [8:0]        CH_LIM  = 9'(CHANNELS);
    localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);
    localparam logic              POL     = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_T_IDX,
        S_L_IDX,
        S_L_LVL
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [TW-1:0]        r_to;
    logic [TW-1:0]        w_to_next;
    logic [7:0]           r_idx;
    logic                 w_idx_we;
    logic [CHANNELS-1:0]  r_en;
    logic [CHANNELS-1:0]  w_tgl;
    logic [CHANNELS-1:0]  w_lit;
    logic [CHANNELS-1:0]  r_led;
    logic                 w_clr;
    logic                 w_lvl_we;
    logic                 w_err;
    logic                 w_treq;
    logic [7:0]           w_tch;
    logic                 r_err;
    logic [PWM_BITS-1:0]  r_pc;
    logic                 w_wrap;
    logic [PWM_BITS-1:0]  w_lvl;
    logic [PWM_BITS-1:0]  r_shadow [CHANNELS];
    logic [PWM_BITS-1:0]  r_active [CHANNELS];

    always_comb begin
        w_next    = r_state;
        w_to_next = r_to;
        w_idx_we  = 1'b0;
        w_clr     = 1'b0;
        w_lvl_we  = 1'b0;
        w_err     = 1'b0;
        w_treq    = 1'b0;
        w_tch     = 8'd0;
        w_tgl     = '0;
        if (r_state == S_IDLE) begin
            w_to_next = '0;
            if (CmdValid) begin
                case (Cmd)
                    8'd82: begin w_treq = 1'b1; w_tch = 8'd0; end
                    8'd71: begin w_treq = 1'b1; w_tch = 8'd1; end
                    8'd66: begin w_treq = 1'b1; w_tch = 8'd2; end
                    8'd84: w_next = S_T_IDX;
                    8'd76: w_next = S_L_IDX;
                    8'd88: w_clr = 1'b1;
                    default: w_err = 1'b1;
                endcase
            end
        end else if (CmdValid) begin
            w_to_next = '0;
            w_next    = S_IDLE;
            case (r_state)
                S_T_IDX: begin
                    w_treq = 1'b1;
                    w_tch  = Cmd;
                end
                S_L_IDX: begin
                    if ({1'b0, Cmd} < CH_LIM) begin
                        w_idx_we = 1'b1;
                        w_next   = S_L_LVL;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: w_lvl_we = 1'b1;
            endcase
        end else if (r_to == TO_LAST) begin
            // Abandoned multi-byte command: drop it and flag
            w_to_next = '0;
            w_next    = S_IDLE;
            w_err     = 1'b1;
        end else begin
            w_to_next = r_to + 1'b1;
        end

        if (w_treq) begin
            if ({1'b0, w_tch} < CH_LIM) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_tch == 8'(i)) begin
                        w_tgl[i] = 1'b1;
                    end
                end
            end else begin
                w_err = 1'b1;
            end
        end
    end

    assign w_wrap = (r_pc == PC_LAST);
    assign w_lvl  = PWM_BITS'(Cmd);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_lit[i] = r_en[i] && (r_pc < r_active[i]);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_to    <= '0;
            r_idx   <= 8'd0;
            r_en    <= '0;
            r_err   <= 1'b0;
            r_pc    <= '0;
            r_led   <= {CHANNELS{POL}};
        end else begin
            r_state <= w_next;
            r_to    <= w_to_next;
            r_err   <= w_err;
            r_led   <= w_lit ^ {CHANNELS{POL}};
            r_pc    <= w_wrap ? '0 : r_pc + 1'b1;
            if (w_idx_we) begin
                r_idx <= Cmd;
            end
            if (w_clr) begin
                r_en <= '0;
            end else begin
                r_en <= r_en ^ w_tgl;
            end
        end
    end

    // Active levels only change at the wrap so a PWM period is never cut short
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_shadow[i] <= LVL_MAX;
                r_active[i] <= LVL_MAX;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_lvl_we && (r_idx == 8'(i))) begin
                    r_shadow[i] <= w_lvl;
                end
                if (w_wrap) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    assign Led      = r_led;
    assign Enabled  = r_en;
    assign CmdError = r_err;

endmodule

// File: tb/tb_led_pwm_cmd_ctrl.sv
// tb/tb_led_pwm_cmd_ctrl.sv - self-checking bench for led_pwm_cmd_ctrl
module tb_led_pwm_cmd_ctrl;

    logic       Clock;
    logic       Reset;
    logic [7:0] Cmd;
    logic       CmdValid;
    logic [2:0] Led;
    logic [2:0] Enabled;
    logic       CmdError;

    int nerr;
    int nchk;
    int cyc;

    led_pwm_cmd_ctrl #(
        .CHANNELS  (3),
        .PWM_BITS  (4),
        .TIMEOUT   (16),
        .ACTIVE_LOW(1)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Cmd     (Cmd),
        .CmdValid(CmdValid),
        .Led     (Led),
        .Enabled (Enabled),
        .CmdError(CmdError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Edges since reset release; after edge n the PWM counter equals n mod 15
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic [7:0] cmd;
        logic       valid;
        logic [2:0] en;
        logic       err;
        logic       lchk;
        logic [2:0] led;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic v);
        @(negedge Clock);
        Cmd      = b;
        CmdValid = v;
        @(posedge Clock);
        #1;
        CmdValid = 1'b0;
    endtask

    initial begin
        int m;
        int w;
        int p;
        logic lit;

        nerr = 0;
        nchk = 0;
        Reset = 1'b0;
        Cmd = 8'd0;
        CmdValid = 1'b0;

        tbl[0]  = '{8'h52, 1'b1, 3'b001, 1'b0, 1'b1, 3'b111};
        tbl[1]  = '{8'h47, 1'b1, 3'b011, 1'b0, 1'b1, 3'b110};
        tbl[2]  = '{8'h42, 1'b1, 3'b111, 1'b0, 1'b1, 3'b100};
        tbl[3]  = '{8'h00, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[4]  = '{8'h00, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[5]  = '{8'h54, 1'b1, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[6]  = '{8'h03, 1'b1, 3'b111, 1'b1, 1'b1, 3'b000};
        tbl[7]  = '{8'h00, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[8]  = '{8'h54, 1'b1, 3'b111, 1'b0, 1'b0, 3'b000};
        tbl[9]  = '{8'h00, 1'b1, 3'b110, 1'b0, 1'b1, 3'b000};
        tbl[10] = '{8'h00, 1'b0, 3'b110, 1'b0, 1'b1, 3'b001};
        tbl[11] = '{8'h41, 1'b1, 3'b110, 1'b1, 1'b1, 3'b001};
        tbl[12] = '{8'h52, 1'b1, 3'b111, 1'b0, 1'b1, 3'b001};
        tbl[13] = '{8'h54, 1'b1, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[14] = '{8'h52, 1'b1, 3'b111, 1'b1, 1'b1, 3'b000};
        tbl[15] = '{8'h4C, 1'b1, 3'b111, 1'b0, 1'b1, 3'b000};
        tbl[16] = '{8'h05, 1'b1, 3'b111, 1'b1, 1'b1, 3'b000};
        tbl[17] = '{8'h58, 1'b1, 3'b000, 1'b0, 1'b1, 3'b000};
        tbl[18] = '{8'h00, 1'b0, 3'b000, 1'b0, 1'b1, 3'b111};
        tbl[19] = '{8'h58, 1'b1, 3'b000, 1'b0, 1'b1, 3'b111};

        repeat (3) @(posedge Clock);
        #1;
        chk("rst_led", Led, 3'b111);
        chk("rst_en", Enabled, 3'b000);
        chk("rst_err", CmdError, 0);
        @(negedge Clock);
        Reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            send(tbl[i].cmd, tbl[i].valid);
            chk($sformatf("vec%0d_en", i), Enabled, tbl[i].en);
            chk($sformatf("vec%0d_err", i), CmdError, tbl[i].err);
            if (tbl[i].lchk) chk($sformatf("vec%0d_led", i), Led, tbl[i].led);
        end

        // Level 4 on channel 1; upper nibble of the level byte must be ignored
        send(8'h47, 1'b1);
        send(8'h4C, 1'b1);
        send(8'h01, 1'b1);
        send(8'h14, 1'b1);
        m = cyc;
        w = m + 1;
        while (w % 15 != 0) w++;
        for (int k = 0; k < 40; k++) begin
            send(8'h00, 1'b0);
            p = cyc - 1;
            lit = (p >= w) ? ((p % 15) < 4) : 1'b1;
            chk($sformatf("pwm4_c%0d", k), Led, {1'b1, ~lit, 1'b1});
        end

        // Inter-byte timeout in L_LVL
        send(8'h4C, 1'b1);
        send(8'h00, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            send(8'h00, 1'b0);
            chk($sformatf("tmo_%0d", k), CmdError, (k == 16) ? 1 : 0);
        end

        // Level 0 keeps an enabled channel dark
        send(8'h52, 1'b1);
        chk("lvl0_en", Enabled, 3'b011);
        send(8'h4C, 1'b1);
        send(8'h00, 1'b1);
        send(8'h00, 1'b1);
        repeat (16) send(8'h00, 1'b0);
        for (int k = 0; k < 20; k++) begin
            send(8'h00, 1'b0);
            chk($sformatf("lvl0_c%0d", k), Led[0], 1);
        end

        // Asynchronous reset in the middle of L,2
        send(8'h4C, 1'b1);
        send(8'h02, 1'b1);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        chk("arst_led", Led, 3'b111);
        chk("arst_en", Enabled, 3'b000);
        chk("arst_err", CmdError, 0);
        @(negedge Clock);
        Reset = 1'b1;
        send(8'h07, 1'b1);
        chk("lone7_err", CmdError, 1);
        chk("lone7_en", Enabled, 3'b000);
        send(8'h52, 1'b1);
        send(8'h47, 1'b1);
        send(8'h42, 1'b1);
        chk("post_en", Enabled, 3'b111);
        for (int k = 0; k < 20; k++) begin
            send(8'h00, 1'b0);
            chk($sformatf("post_led%0d", k), Led, 3'b000);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
